// File: rtl/microwave_controller_if.sv
// Keypad, door and counter-side signals of the microwave controller.
// slave is the controller's view; master is the environment's view.
interface microwave_controller_if;
    logic [3:0] key_digit;
    logic       key_valid;
    logic       start;
    logic       stop_clear;
    logic       door_closed;
    logic       timer_zero;
    logic [3:0] data;
    logic       loadn;
    logic       enable;
    logic       mag_on;
    logic       beep;

    modport slave (
        input  key_digit,
        input  key_valid,
        input  start,
        input  stop_clear,
        input  door_closed,
        input  timer_zero,
        output data,
        output loadn,
        output enable,
        output mag_on,
        output beep
    );

    modport master (
        output key_digit,
        output key_valid,
        output start,
        output stop_clear,
        output door_closed,
        output timer_zero,
        input  data,
        input  loadn,
        input  enable,
        input  mag_on,
        input  beep
    );
endinterface

// File: rtl/microwave_controller.sv
// Microwave timer control FSM: keypad loads, per-second decrement
// enable, door interlock, clear sequence and end-of-cook beep.
module microwave_controller #(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int BEEP_SECONDS  = 3
) (
    input logic                  clock,
    input logic                  clrn,
    microwave_controller_if.slave bus
);
    localparam int PW         = $clog2(TICKS_PER_SEC);
    localparam int BEEP_TOTAL = BEEP_SECONDS * TICKS_PER_SEC;
    localparam int BW         = $clog2(BEEP_TOTAL + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [BW-1:0] BEEP_LAST  = BW'(BEEP_TOTAL - 1);

    typedef enum logic [2:0] {
        IDLE,
        SET,
        COOK,
        PAUSE,
        CLEAR,
        DONE
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_inc;
    logic [BW-1:0] beep_cnt;
    logic [1:0]    clr_cnt;
    logic          digit_ok;
    logic          can_cook;

    assign presc_inc = (presc == PRESC_LAST) ? '0 : presc + PW'(1);
    assign digit_ok  = bus.key_valid && (bus.key_digit <= 4'd9);
    assign can_cook  = bus.door_closed && !bus.timer_zero;

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            state      <= IDLE;
            presc      <= '0;
            beep_cnt   <= '0;
            clr_cnt    <= '0;
            bus.data   <= 4'd0;
            bus.loadn  <= 1'b1;
            bus.enable <= 1'b0;
            bus.mag_on <= 1'b0;
            bus.beep   <= 1'b0;
        end else begin
            bus.loadn  <= 1'b1;
            bus.enable <= 1'b0;
            unique case (state)
                IDLE, SET: begin
                    if (bus.stop_clear) begin
                        state     <= CLEAR;
                        clr_cnt   <= 2'd0;
                        bus.data  <= 4'd0;
                        bus.loadn <= 1'b0;
                    end else if (state == SET && bus.start) begin
                        // A start in SET consumes the cycle even if refused.
                        if (can_cook) begin
                            state      <= COOK;
                            presc      <= '0;
                            bus.mag_on <= 1'b1;
                        end
                    end else if (digit_ok) begin
                        state     <= SET;
                        bus.data  <= bus.key_digit;
                        bus.loadn <= 1'b0;
                    end
                end
                COOK: begin
                    // The cycle just spent cooking always counts.
                    presc <= presc_inc;
                    if (bus.stop_clear || !bus.door_closed) begin
                        state      <= PAUSE;
                        bus.mag_on <= 1'b0;
                    end else if (bus.timer_zero && !bus.enable) begin
                        state      <= DONE;
                        bus.mag_on <= 1'b0;
                        bus.beep   <= 1'b1;
                        beep_cnt   <= '0;
                    end else begin
                        bus.enable <= (presc_inc == PRESC_LAST);
                    end
                end
                PAUSE: begin
                    if (bus.stop_clear) begin
                        state     <= CLEAR;
                        clr_cnt   <= 2'd0;
                        bus.data  <= 4'd0;
                        bus.loadn <= 1'b0;
                    end else if (bus.start && bus.door_closed) begin
                        state      <= COOK;
                        bus.mag_on <= 1'b1;
                        bus.enable <= (presc == PRESC_LAST);
                    end
                end
                CLEAR: begin
                    if (clr_cnt == 2'd2) begin
                        state   <= IDLE;
                        presc   <= '0;
                        clr_cnt <= 2'd0;
                    end else begin
                        clr_cnt   <= clr_cnt + 2'd1;
                        bus.data  <= 4'd0;
                        bus.loadn <= 1'b0;
                    end
                end
                DONE: begin
                    if (bus.stop_clear || !bus.door_closed
                        || beep_cnt == BEEP_LAST) begin
                        state    <= IDLE;
                        bus.beep <= 1'b0;
                        beep_cnt <= '0;
                    end else begin
                        beep_cnt <= beep_cnt + BW'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    bus.mag_on <= 1'b0;
                    bus.beep   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_microwave_controller.sv
// Directed bench for microwave_controller with TICKS_PER_SEC=4, BEEP_SECONDS=3.
module tb_microwave_controller;
    localparam int TPS  = 4;
    localparam int BEEP = 3;

    logic clock = 1'b0;
    logic clrn  = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   n;

    microwave_controller_if bus();

    microwave_controller #(
        .TICKS_PER_SEC(TPS),
        .BEEP_SECONDS (BEEP)
    ) dut (
        .clock(clock),
        .clrn (clrn),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic key(input logic [3:0] d);
        bus.key_valid = 1'b1;
        bus.key_digit = d;
        step();
        bus.key_valid = 1'b0;
    endtask

    task automatic pulse_start;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic pulse_stop;
        bus.stop_clear = 1'b1;
        step();
        bus.stop_clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.key_digit   = 4'd0;
        bus.key_valid   = 1'b0;
        bus.start       = 1'b0;
        bus.stop_clear  = 1'b0;
        bus.door_closed = 1'b1;
        bus.timer_zero  = 1'b0;
        repeat (2) step();
        chk("rst_loadn", bus.loadn, 1);
        chk("rst_data", bus.data, 0);
        chk("rst_enable", bus.enable, 0);
        chk("rst_mag", bus.mag_on, 0);
        chk("rst_beep", bus.beep, 0);
        clrn = 1'b1;
        step();

        // digit entry, back to back
        key(4'd1);
        chk("key1_loadn", bus.loadn, 0);
        chk("key1_data", bus.data, 1);
        key(4'd3);
        chk("key3_loadn", bus.loadn, 0);
        chk("key3_data", bus.data, 3);
        key(4'd0);
        chk("key0_loadn", bus.loadn, 0);
        chk("key0_data", bus.data, 0);
        step();
        chk("key_end_loadn", bus.loadn, 1);
        chk("key_end_enable", bus.enable, 0);

        key(4'd12);
        chk("key12_ignored", bus.loadn, 1);

        // stop_clear beats start and key in SET
        bus.stop_clear = 1'b1;
        bus.start      = 1'b1;
        bus.key_valid  = 1'b1;
        bus.key_digit  = 4'd5;
        step();
        bus.stop_clear = 1'b0;
        bus.start      = 1'b0;
        bus.key_valid  = 1'b0;
        chk("prio_clr1_loadn", bus.loadn, 0);
        chk("prio_clr1_data", bus.data, 0);
        chk("prio_mag", bus.mag_on, 0);
        step();
        chk("prio_clr2_loadn", bus.loadn, 0);
        chk("prio_clr2_data", bus.data, 0);
        step();
        chk("prio_clr3_loadn", bus.loadn, 0);
        chk("prio_clr3_data", bus.data, 0);
        step();
        chk("prio_clr_end", bus.loadn, 1);
        pulse_start();
        chk("idle_start_mag", bus.mag_on, 0);
        step();
        chk("idle_start_mag2", bus.mag_on, 0);

        // load 0:05, door interlock on start
        key(4'd0);
        key(4'd0);
        key(4'd5);
        step();
        bus.door_closed = 1'b0;
        pulse_start();
        chk("open_start_mag", bus.mag_on, 0);
        step();
        chk("open_start_mag2", bus.mag_on, 0);
        bus.door_closed = 1'b1;
        step();

        // short cook: enable every 4th cycle
        pulse_start();
        n = 0;
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) step();
            chk("cook_mag", bus.mag_on, 1);
            chk("cook_enable", bus.enable, (c % 4 == 0) ? 1 : 0);
            chk("cook_loadn", bus.loadn, 1);
            if (bus.enable) n++;
        end
        chk("cook_pulses", n, 5);
        step();
        chk("zero_cycle_enable", bus.enable, 0);
        bus.timer_zero = 1'b1;
        step();
        chk("done_mag", bus.mag_on, 0);
        chk("done_beep", bus.beep, 1);
        n = 0;
        while (bus.beep && n < 40) begin
            n++;
            step();
        end
        chk("beep_len", n, BEEP * TPS);
        bus.timer_zero = 1'b0;
        pulse_start();
        chk("after_done_idle", bus.mag_on, 0);

        // door opened mid-cook after 2 pulses, phase kept
        key(4'd7);
        step();
        pulse_start();
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) step();
            chk("cook2_mag", bus.mag_on, 1);
            chk("cook2_enable", bus.enable, (c % 4 == 0) ? 1 : 0);
            chk("cook2_loadn", bus.loadn, 1);
            bus.key_valid = (c == 2);
            bus.key_digit = 4'd4;
            if (c == 10) bus.door_closed = 1'b0;
        end
        step();
        for (int i = 0; i < 6; i++) begin
            chk("pause_mag", bus.mag_on, 0);
            chk("pause_enable", bus.enable, 0);
            bus.start = (i == 2);
            step();
        end
        bus.start = 1'b0;
        bus.door_closed = 1'b1;
        pulse_start();
        chk("resume_mag", bus.mag_on, 1);
        chk("resume_enable0", bus.enable, 0);
        for (int k = 2; k <= 6; k++) begin
            step();
            chk("resume_enable", bus.enable, (k == 2 || k == 6) ? 1 : 0);
        end

        // stop_clear: COOK -> PAUSE -> CLEAR
        pulse_stop();
        chk("stop_pause_mag", bus.mag_on, 0);
        step();
        chk("stop_pause_enable", bus.enable, 0);
        pulse_stop();
        for (int i = 0; i < 3; i++) begin
            chk("pclr_loadn", bus.loadn, 0);
            chk("pclr_data", bus.data, 0);
            step();
        end
        chk("pclr_end_loadn", bus.loadn, 1);
        pulse_start();
        chk("pclr_idle_start", bus.mag_on, 0);

        // async reset mid-cook, landing on an enable cycle
        key(4'd2);
        step();
        pulse_start();
        repeat (3) step();
        chk("pre_rst_mag", bus.mag_on, 1);
        chk("pre_rst_enable", bus.enable, 1);
        #3 clrn = 1'b0;
        #1;
        chk("arst_mag", bus.mag_on, 0);
        chk("arst_enable", bus.enable, 0);
        chk("arst_beep", bus.beep, 0);
        chk("arst_loadn", bus.loadn, 1);
        #3 clrn = 1'b1;
        step();
        step();
        chk("post_rst_mag", bus.mag_on, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
